// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: data-bus signals shared by the CPU and the memory-mapped UART transmitter
interface uart_tx_mmio_if;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        memwrite;
    logic        memread;
    logic [3:0]  sign_mask;
    logic        hit;
    modport master (
        output addr, write_data, memwrite, memread, sign_mask,
        input  read_data, hit
    );
    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask,
        output read_data, hit
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a TX FIFO and a status register
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_mmio_if.slave  bus,
    output logic           tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          overflow, full, empty, baud_end, push_req, push, pop, ovf_clr;
    logic [31:0]   status;
    logic          unused_bits;
    always_comb begin
        bus.hit   = bus.addr[31:3] == BASE_ADDR[31:3];
        full      = count == (AW+1)'(FIFO_DEPTH);
        empty     = count == '0;
        baud_end  = baud == CW'(CLKS_PER_BIT - 1);
        push_req  = bus.hit & bus.memwrite & !bus.addr[2] & bus.sign_mask[0];
        ovf_clr   = bus.hit & bus.memwrite & bus.addr[2] & bus.sign_mask[0] & bus.write_data[3];
        pop       = !empty & (state == IDLE | (state == STOP & baud_end));
        // a full FIFO still accepts a byte when the head leaves on the same edge
        push      = push_req & (!full | pop);
        status    = 32'({count, overflow, empty, full, state != IDLE});
        bus.read_data = (bus.hit & bus.memread & bus.addr[2]) ? status : '0;
    end
    assign unused_bits = ^{bus.addr[1:0], bus.write_data[31:8], bus.sign_mask[3:1]};
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= bus.write_data[7:0];
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            overflow <= (push_req & full & !pop) | (overflow & !ovf_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            baud <= (state == IDLE || baud_end) ? '0 : baud + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    shreg <= mem[head];
                    tx    <= 1'b0;
                    state <= START;
                end
                START: if (baud_end) begin
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (baud_end) begin
                    if (bit_idx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: if (baud_end) begin
                    if (pop) begin
                        shreg <= mem[head];
                        tx    <= 1'b0;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
